// File: rtl/vend_disp_pkg.sv
// Shared display-code definitions for the vending display path: code constants,
// the 16 active-low segment patterns {g,f,e,d,c,b,a}, and a lookup helper.
package vend_disp_pkg;

    typedef logic [3:0] disp_code_t;

    localparam disp_code_t CODE_R     = 4'hA;
    localparam disp_code_t CODE_DASH  = 4'hB;
    localparam disp_code_t CODE_O     = 4'hC;
    localparam disp_code_t CODE_D     = 4'hD;
    localparam disp_code_t CODE_E     = 4'hE;
    localparam disp_code_t CODE_BLANK = 4'hF;

    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h2F, 7'h3F,   // 8 9 r -
        7'h23, 7'h21, 7'h06, 7'h7F    // o d E blank
    };

    function automatic logic [6:0] seg_pattern(input disp_code_t code);
        return SEG_PATTERNS[code];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational display-code to active-low seven-segment decoder.
module seg7_decode
    import vend_disp_pkg::*;
(
    input  disp_code_t   code,
    output logic [6:0]   seg_n
);

    always_comb begin
        seg_n = seg_pattern(code);
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode scanner: per-frame snapshot, leading-zero blanking,
// 8-level PWM per digit slot, registered pin outputs.
module seven_seg_scanner
    import vend_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       lz_suppress,
    input  logic [2:0] brightness,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       frame_start
);

    localparam int unsigned CW      = $clog2(REFRESH_DIV);
    localparam int unsigned SUB_LEN = REFRESH_DIV / 8;

    logic [CW-1:0] div_cnt;
    logic [1:0]    idx;
    disp_code_t    snap3, snap2, snap1, snap0;
    logic [2:0]    snap_bright;

    logic          slot_last;
    logic          frame_now;
    disp_code_t    sel_code;
    logic          sel_blank;
    logic          blank3;
    logic          blank2;
    logic [CW-1:0] sub;
    logic          lit;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    // Disabled scanner parks at (div_cnt=0, idx=3), so every enabled cycle in
    // that state is by definition a frame start, including after reset/enable.
    always_comb begin
        slot_last = (div_cnt == CW'(REFRESH_DIV - 1));
        frame_now = enable && (div_cnt == '0) && (idx == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= 2'd3;
        end else if (!enable) begin
            div_cnt <= '0;
            idx     <= 2'd3;
        end else if (slot_last) begin
            div_cnt <= '0;
            idx     <= idx - 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap3       <= CODE_BLANK;
            snap2       <= CODE_BLANK;
            snap1       <= CODE_BLANK;
            snap0       <= CODE_BLANK;
            snap_bright <= 3'd7;
        end else if (frame_now) begin
            snap3       <= digit3;
            snap2       <= digit2;
            snap1       <= digit1;
            snap0       <= digit0;
            snap_bright <= brightness;
        end
    end

    always_comb begin
        blank3 = lz_suppress && (snap3 == 4'h0);
        blank2 = blank3 && (snap2 == 4'h0);
        sel_code  = snap0;
        sel_blank = 1'b0;
        case (idx)
            2'd3: begin sel_code = snap3; sel_blank = blank3; end
            2'd2: begin sel_code = snap2; sel_blank = blank2; end
            2'd1: sel_code = snap1;
            default: sel_code = snap0;
        endcase
    end

    seg7_decode u_decode (
        .code  (sel_code),
        .seg_n (dec_seg)
    );

    always_comb begin
        sub = div_cnt / CW'(SUB_LEN);
        lit = (div_cnt != '0) && (sub <= CW'(snap_bright));
        an_next  = 4'hF;
        seg_next = 7'h7F;
        if (enable) begin
            seg_next = sel_blank ? 7'h7F : dec_seg;
            if (lit) begin
                an_next = ~(4'b0001 << idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n       <= 7'h7F;
            an_n        <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            seg_n       <= seg_next;
            an_n        <= an_next;
            frame_start <= frame_now;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with REFRESH_DIV=16: position-based reference model
// checked every cycle, plus directed frames with literal segment/anode expectations.
module tb_seven_seg_scanner;

    localparam int unsigned DIV   = 16;
    localparam int unsigned FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       lz_suppress = 1'b0;
    logic [2:0] brightness = 3'd7;
    logic [3:0] digit3 = 4'h1, digit2 = 4'h2, digit1 = 4'h3, digit0 = 4'h0;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .digit3      (digit3),
        .digit2      (digit2),
        .digit1      (digit1),
        .digit0      (digit0),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        logic [6:0] tab [16];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0101111, 7'b0111111,
                7'b0100011, 7'b0100001, 7'b0000110, 7'b1111111};
        return tab[c];
    endfunction

    // Outputs for an enabled cycle that is cnt cycles into the scan sequence.
    function automatic logic [11:0] ref_out(input int unsigned cnt, input logic [15:0] snap,
                                            input logic [2:0] br, input logic lz);
        int unsigned p, d, phase;
        logic [3:0] code;
        logic       blank;
        logic [3:0] an;
        logic [3:0] one;
        p     = cnt % FRAME;
        d     = 3 - p / DIV;
        phase = p % DIV;
        code  = snap[d*4 +: 4];
        blank = (d == 3 && lz && snap[15:12] == 4'h0) ||
                (d == 2 && lz && snap[15:8] == 8'h00);
        one   = 4'b0001;
        an    = (phase != 0 && phase / (DIV / 8) <= br) ? ~(one << d) : 4'hF;
        return {(p == 0), an, blank ? 7'h7F : ref_seg(code)};
    endfunction

    int unsigned m_cnt;
    logic [15:0] m_snap;
    logic [2:0]  m_bright;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_fs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= 0;
            m_snap   <= 16'hFFFF;
            m_bright <= 3'd7;
            exp_seg  <= 7'h7F;
            exp_an   <= 4'hF;
            exp_fs   <= 1'b0;
        end else if (!enable) begin
            m_cnt   <= 0;
            exp_seg <= 7'h7F;
            exp_an  <= 4'hF;
            exp_fs  <= 1'b0;
        end else begin
            {exp_fs, exp_an, exp_seg} <= ref_out(m_cnt, m_snap, m_bright, lz_suppress);
            if (m_cnt % FRAME == 0) begin
                m_snap   <= {digit3, digit2, digit1, digit0};
                m_bright <= brightness;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_cmp = n_cmp + 1;
            if ({frame_start, an_n, seg_n} !== {exp_fs, exp_an, exp_seg}) begin
                n_bad = n_bad + 1;
                if (n_bad < 40)
                    $display("FAIL model t=%0t: got fs=%b an=%b seg=%b, want fs=%b an=%b seg=%b",
                             $time, frame_start, an_n, seg_n, exp_fs, exp_an, exp_seg);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp = n_cmp + 1;
        if (act !== expv) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, want %0h", name, act, expv);
        end
    endtask

    task automatic wait_fs(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        check({name, " frame_start seen"}, 32'(seen), 32'd1);
    endtask

    int         obs_on    [4];
    int         obs_first [4];
    logic [6:0] obs_seg   [4];

    task automatic observe(input bit do_chg, input logic [15:0] chg_val);
        for (int i = 0; i < 4; i++) begin
            obs_on[i] = 0; obs_first[i] = -1; obs_seg[i] = 7'hxx;
        end
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (do_chg && k == 40) {digit3, digit2, digit1, digit0} = chg_val;
            for (int i = 0; i < 4; i++) begin
                if (an_n[i] === 1'b0) begin
                    if (obs_first[i] < 0) obs_first[i] = k;
                    obs_on[i]  = obs_on[i] + 1;
                    obs_seg[i] = seg_n;
                end
            end
        end
    endtask

    task automatic run_case(input string name, input logic [15:0] dig, input logic [2:0] br,
                            input logic lz, input logic [27:0] segs, input int on_exp,
                            input bit do_chg, input logic [15:0] chg_val);
        {digit3, digit2, digit1, digit0} = dig;
        brightness  = br;
        lz_suppress = lz;
        wait_fs(name);
        observe(do_chg, chg_val);
        for (int i = 3; i >= 0; i--) begin
            check($sformatf("%s seg%0d", name, i), 32'(obs_seg[i]), 32'(segs[i*7 +: 7]));
            check($sformatf("%s on%0d", name, i), 32'(obs_on[i]), 32'(on_exp));
            check($sformatf("%s first%0d", name, i), 32'(obs_first[i]), 32'(1 + DIV * (3 - i)));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("reset an_n", 32'(an_n), 32'hF);
        check("reset seg_n", 32'(seg_n), 32'h7F);
        check("reset fs", 32'(frame_start), 32'd0);
        rst_n = 1'b1;

        run_case("basic", 16'h1230, 3'd7, 1'b0,
                 {7'b1111001, 7'b0100100, 7'b0110000, 7'b1000000}, 15, 1'b0, 16'h0);
        run_case("lz0050", 16'h0050, 3'd7, 1'b1,
                 {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 15, 1'b0, 16'h0);
        run_case("lz0700", 16'h0700, 3'd7, 1'b1,
                 {7'h7F, 7'b1111000, 7'b1000000, 7'b1000000}, 15, 1'b0, 16'h0);
        run_case("codes", 16'hEAAF, 3'd7, 1'b0,
                 {7'b0000110, 7'b0101111, 7'b0101111, 7'h7F}, 15, 1'b0, 16'h0);
        run_case("br0", 16'h8888, 3'd0, 1'b0,
                 {7'h00, 7'h00, 7'h00, 7'h00}, 1, 1'b0, 16'h0);
        run_case("br3", 16'h4679, 3'd3, 1'b0,
                 {7'b0011001, 7'b0000010, 7'b1111000, 7'b0010000}, 7, 1'b0, 16'h0);

        // New digits arrive in the idx=1 slot; the old frame must finish unchanged.
        run_case("midchg", 16'h1230, 3'd7, 1'b0,
                 {7'b1111001, 7'b0100100, 7'b0110000, 7'b1000000}, 15, 1'b1, 16'h8888);
        check("midchg fs at frame end", 32'(frame_start), 32'd1);
        @(negedge clk);
        check("midchg new an", 32'(an_n), 32'b0111);
        check("midchg new seg", 32'(seg_n), 32'h00);

        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("disable an_n", 32'(an_n), 32'hF);
        check("disable seg_n", 32'(seg_n), 32'h7F);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("reenable fs", 32'(frame_start), 32'd1);
        @(negedge clk);
        check("reenable an", 32'(an_n), 32'b0111);

        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst an_n", 32'(an_n), 32'hF);
        check("async rst seg_n", 32'(seg_n), 32'h7F);
        check("async rst fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst fs", 32'(frame_start), 32'd1);
        repeat (4) @(negedge clk);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed seven-segment scanner that consumes the four 4-bit digit codes from the vending display driver and drives a common-anode 4-digit display. It snapshots the digits once per frame to prevent tearing, decodes the codes to segment patterns, and sequences the anodes. It also applies optional leading-zero suppression and 8-level PWM brightness. It sits between the display driver and the board pins.

## Interface
- REFRESH_DIV, default 50000: clk cycles per digit slot; must be a multiple of 8, minimum 16.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- enable  input  1  high = scan; low = all anodes off and scanner held.
- lz_suppress  input  1  high = blank leading zeros on digit3/digit2.
- brightness  input  3  duty level, 0 = 1/8 slot, 7 = full slot minus ghost cycle.
- digit3, digit2, digit1, digit0  input  4 each  display codes, digit3 leftmost.
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an_n  output  4  anodes, bit i = digit i, active-low.
- frame_start  output  1  one-cycle pulse when a new snapshot is taken.

## Operation
- Code map: 0–9 numerals; A = 'r'; B = '-'; C = 'o'; D = 'd'; E = 'E'; F = blank (all segments off).
- State: div_cnt (0..REFRESH_DIV-1), idx (3..0), and snapshot registers snap3..snap0 plus snap_bright.
- div_cnt increments every cycle while enable is high. At REFRESH_DIV-1 it wraps to 0, and idx then steps 3→2→1→0→3.
- Frame start is the cycle where idx moves to 3, and also the first enabled cycle after reset or after enable rises. On a frame start:
  - digit3..0 and brightness are captured into the snapshot registers.
  - frame_start pulses.
  - Inputs are ignored for the rest of the frame.
- Leading-zero suppression is evaluated on snapshot values:
  - digit3 is blanked if lz_suppress is high and snap3 == 0.
  - digit2 is blanked if digit3 was suppressed and snap2 == 0.
  - digit1 and digit0 are never suppressed.
- PWM:
  - sub = div_cnt / (REFRESH_DIV/8), range 0..7.
  - The anode for idx is on when div_cnt != 0 and sub <= snap_bright.
  - div_cnt == 0 is the anti-ghost cycle: all anodes are off.
- Segments: seg_n = decode(selected snapshot code), or 7'h7F when that digit is suppressed.
- enable low:
  - an_n = 4'hF and seg_n = 7'h7F.
  - div_cnt is held at 0 and idx at 3.
  - The next enabled cycle is a frame start.

## Timing
- Reset values: an_n = 4'hF, seg_n = 7'h7F, frame_start = 0, div_cnt = 0, idx = 3, snapshot codes = 4'hF, snap_bright = 7.
- Release of rst_n with enable high: the first rising edge performs a frame start.
- All outputs are registered. seg_n, an_n, and frame_start reflect the div_cnt/idx state of the previous cycle (1-cycle latency).
- A digit input change appears on the pins no earlier than the next frame start plus 1 cycle, and no later than 4×REFRESH_DIV + 1 cycles after the change.
- Simultaneous frame start and input change: the value present on that edge is captured.
- rst_n asserted mid-frame: all outputs go to reset values immediately (asynchronous), with no completion of the frame.
- At most one bit of an_n is low in any cycle. The anode is always off in the cycle where idx changes.

## Structure
- Shared package vend_disp_pkg:
  - code constants CODE_R = 4'hA, CODE_DASH = 4'hB, CODE_O = 4'hC, CODE_D = 4'hD, CODE_E = 4'hE, CODE_BLANK = 4'hF;
  - the 16 segment patterns;
  - a shared display-code typedef, also used by the display driver.
- Sub-module seg7_decode: combinational, 4-bit code in, 7-bit active-low seg out. It is instantiated once on the muxed snapshot value.
- Top-level scanner: counter, idx sequencer, snapshot, suppression, and PWM compare, with output registers.

## Test plan
All scenarios use REFRESH_DIV = 16.
- Reset with digits 1,2,3,0, brightness 7, then release rst_n:
  - frame_start pulses once;
  - an_n cycles 4'b0111 (seg_n 7'b1111001), 4'b1011 (7'b0100100), 4'b1101 (7'b0110000), 4'b1110 (7'b1000000);
  - each anode is on for 15 of 16 cycles and off on slot cycle 0.
- lz_suppress = 1 with digits 0,0,5,0:
  - digit3 and digit2 slots show seg_n 7'h7F;
  - digit1 shows '5' (7'b0010010) and digit0 shows '0'.
- lz_suppress = 1 with digits 0,7,0,0: only digit3 is blanked, and digit2 shows '7'.
- Code sweep E,A,A,F:
  - digit3 'E' = 7'b0000110;
  - digit2 and digit1 'r' = 7'b0101111;
  - digit0 blank = 7'h7F.
- Digit change mid-frame (during the idx = 1 slot): the display is unchanged until the next frame_start, and the new value appears 1 cycle after it.
- Brightness sweep:
  - brightness 0 gives the anode low for exactly 1 cycle per slot (div_cnt 1);
  - brightness 3 gives 7 cycles per slot;
  - enable dropped mid-slot gives an_n = 4'hF on the next cycle, and the re-enable cycle produces frame_start.
